dmem_sweep_master: RTL and testbench
====================================

# dmem_sweep_master

Block-copy engine that acts as the initiator on the 8-port data-memory interface: it reads up to 8 words per batch through all eight ports and writes them back, optionally bit-inverted, to a destination region using the single shared write enable. It sits between the control FSM and the data memory, replacing CPU-driven word-by-word copies. A bit-0 population count of the written words is kept as a completion statistic.

## Interface
- No parameters. Lane count is 8, word index width is 7, data width is 16.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; accepted only when busy=0.
- src_idx  input  7  source word index, sampled on accept.
- dst_idx  input  7  destination word index, sampled on accept.
- len  input  7  words to copy (0..127), sampled on accept.
- invert  input  1  when 1, write ~data[15:0]; sampled on accept.
- busy  output  1  high from the cycle after accept through the last WR cycle.
- done  output  1  one-cycle pulse at completion.
- ones_cnt  output  8  count of written words with bit0=1 over the current/last command.
- mem_ready  output  1  memory ROM-select. Held 0 while busy, so port 0 reads RAM; 1 when idle.
- we  output  1  shared write enable for all 8 ports.
- a_0..a_7  output  32 each  byte addresses: {23'b0, idx, 2'b00}.
- wd_0..wd_7  output  32 each  write data: {16'b0, data}.
- rd_0..rd_7  input  32 each  combinational read data; only [15:0] is used.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On start, latch src/dst/len/invert, clear ones_cnt and set remaining=len.
  - Go to RD if len≠0, else go to DONE.
- RD:
  - Drive lane i address = src_cur+i (mod 128) for active lanes.
  - Capture rd_i[15:0] (inverted if invert) into lane registers at the clock edge, then go to WR.
- WR:
  - Drive a_i = dst_cur+i (mod 128), wd_i = lane register, we=1.
  - Active lanes = min(remaining, 8).
  - Add the bit0 of each active lane's data to ones_cnt.
  - Then src_cur+=8, dst_cur+=8, remaining-=active.
  - If remaining becomes 0, go to DONE; else go to RD.
- Partial batch: inactive lanes i≥active must mirror lane 0 exactly (same address and data in both RD and WR). Duplicate writes are then harmless under the shared we.
- DONE: done=1 for one cycle, then return to IDLE.
- Index arithmetic is 7-bit and wraps modulo 128 (e.g. src=124 hits 124..127,0..3).
- Overlapping regions: the copy is strictly batch-sequential and forward, with no overlap protection. The result equals the sequence of 8-word read-then-write batches.
- Address outputs outside RD/WR: all a_i = 0, wd_i = 0.
- start while busy or in DONE: ignored, with no effect on the running command.

## Timing
- Reset values: busy=0, done=0, ones_cnt=0, we=0, mem_ready=1, all a_i=0, all wd_i=0, state IDLE.
- Latency:
  - start sampled at edge T; RD in the cycle after T; first WR the next cycle.
  - Each batch takes 2 cycles. done is high in the cycle after the final WR.
  - len=8 gives done 3 cycles after T; len=0 gives done 1 cycle after T.
  - Total latency is 2·ceil(len/8)+1 cycles.
- busy and done are never high together. mem_ready = ~busy.
- ones_cnt updates at the end of each WR cycle and holds its value after done until the next accept.
- Reset mid-command aborts immediately:
  - No done pulse and we drops asynchronously.
  - Writes already performed remain in memory.

## Test plan
- Preload RAM[16..23]=0x0001..0x0008; start src=16 dst=32 len=8 invert=0:
  - RAM[32..39] equals 0x0001..0x0008.
  - ones_cnt=4; done 3 cycles after start; exactly one we cycle.
- len=11 src=16 dst=40 invert=1:
  - Two WR cycles; RAM[40..50] = ~source words.
  - In the second WR, lanes 3..7 carry lane 0's address and data.
  - done at cycle 5.
- len=0: done 1 cycle after start, we never asserted, ones_cnt=0.
- Wrap: src=124 len=8 → read addresses 0x1F0,0x1F4,0x1F8,0x1FC,0x000..0x00C.
- Pulse start during busy: ignored, and the original command completes unchanged.
- Assert rst_n=0 during the first WR of a len=16 copy:
  - Outputs return to reset values, no done.
  - A following start works normally.

Source files
------------

// File: rtl/dmem_sweep_master.sv
// ---------------------------------------------------------------------------
// dmem_sweep_master
//
// Block-copy engine on the 8-port data-memory interface. Each batch reads up
// to eight consecutive words in one cycle (RD) and writes them, optionally
// bit-inverted, to the destination region in the next cycle (WR) using the
// single shared write enable. The number of written words with bit 0 set is
// accumulated in ones_cnt as a completion statistic.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 command strobe, accepted only in IDLE
//   src_idx, dst_idx      7-bit word indices, sampled on accept
//   len                   word count 0..127, sampled on accept
//   invert                write ~data when set, sampled on accept
//   busy                  high in RD and WR
//   done                  one-cycle completion pulse
//   ones_cnt              bit-0 population count of written words
//   mem_ready             memory ROM-select, ~busy
//   we                    shared write enable for all eight ports
//   a_0..a_7              byte addresses {23'b0, idx, 2'b00}
//   wd_0..wd_7            write data {16'b0, data}
//   rd_0..rd_7            combinational read data, [15:0] used
//   dbg_state_o           current FSM state (IDLE=0, RD=1, WR=2, DONE=3)
//
// Handshake: a command is taken when start=1 at a rising edge while the FSM
// is in IDLE; start in any other state is dropped without side effects. done
// is a single-cycle pulse and never overlaps busy.
// ---------------------------------------------------------------------------
module dmem_sweep_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  src_idx,
  input  logic [6:0]  dst_idx,
  input  logic [6:0]  len,
  input  logic        invert,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ones_cnt,
  output logic        mem_ready,
  output logic        we,
  output logic [31:0] a_0,
  output logic [31:0] a_1,
  output logic [31:0] a_2,
  output logic [31:0] a_3,
  output logic [31:0] a_4,
  output logic [31:0] a_5,
  output logic [31:0] a_6,
  output logic [31:0] a_7,
  output logic [31:0] wd_0,
  output logic [31:0] wd_1,
  output logic [31:0] wd_2,
  output logic [31:0] wd_3,
  output logic [31:0] wd_4,
  output logic [31:0] wd_5,
  output logic [31:0] wd_6,
  output logic [31:0] wd_7,
  input  logic [31:0] rd_0,
  input  logic [31:0] rd_1,
  input  logic [31:0] rd_2,
  input  logic [31:0] rd_3,
  input  logic [31:0] rd_4,
  input  logic [31:0] rd_5,
  input  logic [31:0] rd_6,
  input  logic [31:0] rd_7,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;

  logic [6:0]  src_q, src_d;
  logic [6:0]  dst_q, dst_d;
  logic [6:0]  rem_q, rem_d;
  logic        inv_q, inv_d;
  logic [7:0]  ones_q, ones_d;
  logic [15:0] lane_q [8];
  logic [15:0] lane_d [8];

  logic [31:0] a_arr  [8];
  logic [31:0] wd_arr [8];
  logic [15:0] rd_arr [8];

  logic [3:0]  act;
  logic [7:0]  lane_act;
  logic [3:0]  wr_ones;

  // Only the low half of each read port carries data.
  logic        unused_rd_hi;
  assign unused_rd_hi = ^{rd_0[31:16], rd_1[31:16], rd_2[31:16], rd_3[31:16],
                          rd_4[31:16], rd_5[31:16], rd_6[31:16], rd_7[31:16]};

  assign rd_arr[0] = rd_0[15:0];
  assign rd_arr[1] = rd_1[15:0];
  assign rd_arr[2] = rd_2[15:0];
  assign rd_arr[3] = rd_3[15:0];
  assign rd_arr[4] = rd_4[15:0];
  assign rd_arr[5] = rd_5[15:0];
  assign rd_arr[6] = rd_6[15:0];
  assign rd_arr[7] = rd_7[15:0];

  assign a_0 = a_arr[0];
  assign a_1 = a_arr[1];
  assign a_2 = a_arr[2];
  assign a_3 = a_arr[3];
  assign a_4 = a_arr[4];
  assign a_5 = a_arr[5];
  assign a_6 = a_arr[6];
  assign a_7 = a_arr[7];

  assign wd_0 = wd_arr[0];
  assign wd_1 = wd_arr[1];
  assign wd_2 = wd_arr[2];
  assign wd_3 = wd_arr[3];
  assign wd_4 = wd_arr[4];
  assign wd_5 = wd_arr[5];
  assign wd_6 = wd_arr[6];
  assign wd_7 = wd_arr[7];

  assign ones_cnt    = ones_q;
  assign mem_ready   = ~busy;
  assign dbg_state_o = state_q;

  function automatic logic [31:0] idx2addr(input logic [6:0] idx);
    return {23'b0, idx, 2'b00};
  endfunction

  // Active lanes in the current batch: min(remaining, 8). Lanes at or above
  // this count mirror lane 0 so their duplicate writes under the shared we
  // are harmless.
  always_comb begin
    act = (rem_q[6:3] != 4'd0) ? 4'd8 : {1'b0, rem_q[2:0]};
    for (int i = 0; i < 8; i++) begin
      lane_act[i] = (4'(i) < act);
    end
  end

  always_comb begin
    wr_ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (lane_act[i]) begin
        wr_ones = wr_ones + {3'b0, lane_q[i][0]};
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len != 7'd0) ? S_RD : S_DONE;
        end
      end
      S_RD:   state_d = S_WR;
      S_WR:   state_d = (rem_q == {3'b0, act}) ? S_DONE : S_RD;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. Address and data buses are zero outside RD/WR.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    we   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_arr[i]  = 32'd0;
      wd_arr[i] = 32'd0;
    end
    case (state_q)
      S_RD: begin
        busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
          a_arr[i] = idx2addr(lane_act[i] ? (src_q + 7'(i)) : src_q);
        end
      end
      S_WR: begin
        busy = 1'b1;
        we   = 1'b1;
        for (int i = 0; i < 8; i++) begin
          a_arr[i]  = idx2addr(lane_act[i] ? (dst_q + 7'(i)) : dst_q);
          wd_arr[i] = {16'b0, lane_act[i] ? lane_q[i] : lane_q[0]};
        end
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    rem_d  = rem_q;
    inv_d  = inv_q;
    ones_d = ones_q;
    for (int i = 0; i < 8; i++) begin
      lane_d[i] = lane_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_idx;
          dst_d  = dst_idx;
          rem_d  = len;
          inv_d  = invert;
          ones_d = 8'd0;
        end
      end
      S_RD: begin
        for (int i = 0; i < 8; i++) begin
          lane_d[i] = inv_q ? ~rd_arr[i] : rd_arr[i];
        end
      end
      S_WR: begin
        src_d  = src_q + 7'd8;
        dst_d  = dst_q + 7'd8;
        rem_d  = rem_q - {3'b0, act};
        ones_d = ones_q + {4'b0, wr_ones};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= 7'd0;
      dst_q  <= 7'd0;
      rem_q  <= 7'd0;
      inv_q  <= 1'b0;
      ones_q <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        lane_q[i] <= 16'd0;
      end
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      rem_q  <= rem_d;
      inv_q  <= inv_d;
      ones_q <= ones_d;
      for (int i = 0; i < 8; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dmem_sweep_master.sv
module tb_dmem_sweep_master;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  src_idx = 7'd0;
  logic [6:0]  dst_idx = 7'd0;
  logic [6:0]  len = 7'd0;
  logic        invert = 1'b0;
  logic        busy, done, mem_ready, we;
  logic [7:0]  ones_cnt;
  logic [1:0]  dbg_state;
  logic [31:0] a_0, a_1, a_2, a_3, a_4, a_5, a_6, a_7;
  logic [31:0] wd_0, wd_1, wd_2, wd_3, wd_4, wd_5, wd_6, wd_7;
  logic [31:0] rd_0, rd_1, rd_2, rd_3, rd_4, rd_5, rd_6, rd_7;

  always #5 clk = ~clk;

  dmem_sweep_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_idx(src_idx),
    .dst_idx(dst_idx), .len(len), .invert(invert), .busy(busy), .done(done),
    .ones_cnt(ones_cnt), .mem_ready(mem_ready), .we(we),
    .a_0(a_0), .a_1(a_1), .a_2(a_2), .a_3(a_3),
    .a_4(a_4), .a_5(a_5), .a_6(a_6), .a_7(a_7),
    .wd_0(wd_0), .wd_1(wd_1), .wd_2(wd_2), .wd_3(wd_3),
    .wd_4(wd_4), .wd_5(wd_5), .wd_6(wd_6), .wd_7(wd_7),
    .rd_0(rd_0), .rd_1(rd_1), .rd_2(rd_2), .rd_3(rd_3),
    .rd_4(rd_4), .rd_5(rd_5), .rd_6(rd_6), .rd_7(rd_7),
    .dbg_state_o(dbg_state)
  );

  logic [31:0] a_arr [8];
  logic [31:0] wd_arr [8];
  assign a_arr[0] = a_0;  assign a_arr[1] = a_1;
  assign a_arr[2] = a_2;  assign a_arr[3] = a_3;
  assign a_arr[4] = a_4;  assign a_arr[5] = a_5;
  assign a_arr[6] = a_6;  assign a_arr[7] = a_7;
  assign wd_arr[0] = wd_0; assign wd_arr[1] = wd_1;
  assign wd_arr[2] = wd_2; assign wd_arr[3] = wd_3;
  assign wd_arr[4] = wd_4; assign wd_arr[5] = wd_5;
  assign wd_arr[6] = wd_6; assign wd_arr[7] = wd_7;

  // ---------------- memory model ----------------
  logic [15:0] mem [128];
  assign rd_0 = {16'h0, mem[a_0[8:2]]};
  assign rd_1 = {16'h0, mem[a_1[8:2]]};
  assign rd_2 = {16'h0, mem[a_2[8:2]]};
  assign rd_3 = {16'h0, mem[a_3[8:2]]};
  assign rd_4 = {16'h0, mem[a_4[8:2]]};
  assign rd_5 = {16'h0, mem[a_5[8:2]]};
  assign rd_6 = {16'h0, mem[a_6[8:2]]};
  assign rd_7 = {16'h0, mem[a_7[8:2]]};

  always @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < 8; l++) begin
        mem[a_arr[l][8:2]] = wd_arr[l][15:0];
      end
    end
  end

  // ---------------- bookkeeping ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc, we_seen, done_at, proto_bad;

  task automatic observe();
    if (we) we_seen++;
    if (done && done_at < 0) done_at = cyc;
    if ((busy && done) || (mem_ready !== ~busy)) proto_bad++;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  // Returns at the negedge of cycle 1 (the cycle after the accepting edge).
  task automatic issue_start(input logic [6:0] s, input logic [6:0] d,
                             input logic [6:0] l, input logic inv);
    @(negedge clk);
    src_idx = s; dst_idx = d; len = l; invert = inv; start = 1'b1;
    cyc = 0; we_seen = 0; done_at = -1; proto_bad = 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    observe();
  endtask

  task automatic run_to_done(input int budget);
    while (done_at < 0 && cyc < budget) next_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 8; i++) if (a_arr[i] !== 32'd0 || wd_arr[i] !== 32'd0) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL reset_bus got %0d nonzero lanes exp 0", bad); else pass_cnt++;
    total_cnt++;
    if ({busy, done, we, mem_ready} !== 4'b0001)
      $display("FAIL reset_ctrl got busy/done/we/rdy=%b exp 0001", {busy, done, we, mem_ready});
    else pass_cnt++;
    total_cnt++;
    if (ones_cnt !== 8'd0 || dbg_state !== 2'd0)
      $display("FAIL reset_state got ones=%0d st=%0d exp 0/0", ones_cnt, dbg_state);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || we !== 1'b0) $display("FAIL reset_idle got busy=%b we=%b exp 0/0", busy, we);
    else pass_cnt++;
  endtask

  task automatic test_copy8();
    for (int k = 0; k < 8; k++) mem[16+k] = 16'(k + 1);
    issue_start(7'd16, 7'd32, 7'd8, 1'b0);
    total_cnt++;
    if (a_0 !== 32'h40 || a_7 !== 32'h5C || busy !== 1'b1 || we !== 1'b0)
      $display("FAIL copy8_rd got a0=%h a7=%h busy=%b we=%b exp 40/5c/1/0", a_0, a_7, busy, we);
    else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (we !== 1'b1 || a_3 !== 32'h8C || wd_3 !== 32'h4)
      $display("FAIL copy8_wr got we=%b a3=%h wd3=%h exp 1/8c/4", we, a_3, wd_3);
    else pass_cnt++;
    run_to_done(20);
    total_cnt++;
    if (done_at !== 3) $display("FAIL copy8_latency got %0d exp 3", done_at); else pass_cnt++;
    total_cnt++;
    if (we_seen !== 1) $display("FAIL copy8_we_cycles got %0d exp 1", we_seen); else pass_cnt++;
    total_cnt++;
    if (ones_cnt !== 8'd4) $display("FAIL copy8_ones got %0d exp 4", ones_cnt); else pass_cnt++;
    total_cnt++;
    if (proto_bad !== 0) $display("FAIL copy8_protocol got %0d exp 0", proto_bad); else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || ones_cnt !== 8'd4)
      $display("FAIL copy8_hold got busy=%b done=%b ones=%0d exp 0/0/4", busy, done, ones_cnt);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      total_cnt++;
      if (mem[32+k] !== 16'(k + 1))
        $display("FAIL copy8_mem[%0d] got %h exp %h", 32 + k, mem[32+k], 16'(k + 1));
      else pass_cnt++;
    end
  endtask

  task automatic test_partial_invert();
    logic [15:0] exp_w [11];
    int bad;
    mem[24] = 16'h0100; mem[25] = 16'h0201; mem[26] = 16'h0300;
    for (int k = 0; k < 8; k++) exp_w[k] = ~16'(k + 1);
    exp_w[8] = 16'hFEFF; exp_w[9] = 16'hFDFE; exp_w[10] = 16'hFCFF;
    issue_start(7'd16, 7'd40, 7'd11, 1'b1);
    next_cycle();
    next_cycle();
    total_cnt++;
    if (a_2 !== 32'h68 || a_3 !== 32'h60 || a_7 !== 32'h60)
      $display("FAIL part_rd_mirror got a2=%h a3=%h a7=%h exp 68/60/60", a_2, a_3, a_7);
    else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (we !== 1'b1 || a_0 !== 32'hC0 || a_2 !== 32'hC8 || wd_0 !== 32'hFEFF || wd_2 !== 32'hFCFF)
      $display("FAIL part_wr_lanes got a0=%h a2=%h wd0=%h wd2=%h exp c0/c8/feff/fcff", a_0, a_2, wd_0, wd_2);
    else pass_cnt++;
    for (int i = 3; i < 8; i++) begin
      total_cnt++;
      if (a_arr[i] !== 32'hC0 || wd_arr[i] !== 32'hFEFF)
        $display("FAIL part_wr_mirror%0d got a=%h wd=%h exp c0/feff", i, a_arr[i], wd_arr[i]);
      else pass_cnt++;
    end
    run_to_done(20);
    total_cnt++;
    if (done_at !== 5) $display("FAIL part_latency got %0d exp 5", done_at); else pass_cnt++;
    total_cnt++;
    if (we_seen !== 2) $display("FAIL part_we_cycles got %0d exp 2", we_seen); else pass_cnt++;
    total_cnt++;
    if (ones_cnt !== 8'd6) $display("FAIL part_ones got %0d exp 6", ones_cnt); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 11; k++) if (mem[40+k] !== exp_w[k]) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL part_mem got %0d bad words exp 0", bad); else pass_cnt++;
    total_cnt++;
    if (mem[51] !== 16'h5A5A) $display("FAIL part_no_overrun got %h exp 5a5a", mem[51]); else pass_cnt++;
  endtask

  task automatic test_len0();
    issue_start(7'd5, 7'd60, 7'd0, 1'b0);
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL len0_done got done=%b busy=%b exp 1/0", done, busy);
    else pass_cnt++;
    total_cnt++;
    if (ones_cnt !== 8'd0) $display("FAIL len0_ones got %0d exp 0", ones_cnt); else pass_cnt++;
    next_cycle();
    next_cycle();
    total_cnt++;
    if (done_at !== 1 || we_seen !== 0 || done !== 1'b0)
      $display("FAIL len0_seq got done_at=%0d we=%0d done=%b exp 1/0/0", done_at, we_seen, done);
    else pass_cnt++;
    total_cnt++;
    if (mem[60] !== 16'h5A5A) $display("FAIL len0_mem got %h exp 5a5a", mem[60]); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [8];
    logic [15:0] exp_w [8];
    int bad;
    exp_a = '{32'h1F0, 32'h1F4, 32'h1F8, 32'h1FC, 32'h000, 32'h004, 32'h008, 32'h00C};
    exp_w = '{16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04, 16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04};
    for (int k = 0; k < 4; k++) begin
      mem[124+k] = 16'h0C01 + 16'(k);
      mem[k]     = 16'h0D01 + 16'(k);
    end
    issue_start(7'd124, 7'd64, 7'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (a_arr[i] !== exp_a[i]) $display("FAIL wrap_a%0d got %h exp %h", i, a_arr[i], exp_a[i]);
      else pass_cnt++;
    end
    run_to_done(20);
    total_cnt++;
    if (done_at !== 3) $display("FAIL wrap_latency got %0d exp 3", done_at); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 8; k++) if (mem[64+k] !== exp_w[k]) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL wrap_mem got %0d bad words exp 0", bad); else pass_cnt++;
  endtask

  task automatic test_busy_start();
    logic [15:0] exp_w [16];
    int bad;
    for (int k = 0; k < 8; k++) exp_w[k] = 16'(k + 1);
    exp_w[8] = 16'h0100; exp_w[9] = 16'h0201; exp_w[10] = 16'h0300;
    for (int k = 0; k < 5; k++) begin
      mem[27+k] = 16'h0E01 + 16'(k);
      exp_w[11+k] = 16'h0E01 + 16'(k);
    end
    issue_start(7'd16, 7'd80, 7'd16, 1'b0);
    next_cycle();
    src_idx = 7'd0; dst_idx = 7'd100; len = 7'd3; invert = 1'b1; start = 1'b1;
    next_cycle();
    start = 1'b0;
    run_to_done(20);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL busy_done_start got busy=%b st=%0d exp 0/0", busy, dbg_state);
    else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (done_at !== 5 || we_seen !== 2)
      $display("FAIL busy_seq got done_at=%0d we=%0d exp 5/2", done_at, we_seen);
    else pass_cnt++;
    total_cnt++;
    if (ones_cnt !== 8'd8) $display("FAIL busy_ones got %0d exp 8", ones_cnt); else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 16; k++) if (mem[80+k] !== exp_w[k]) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL busy_mem got %0d bad words exp 0", bad); else pass_cnt++;
    total_cnt++;
    if (mem[100] !== 16'h5A5A) $display("FAIL busy_ignored got %h exp 5a5a", mem[100]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    int bad;
    issue_start(7'd16, 7'd110, 7'd16, 1'b0);
    next_cycle();
    total_cnt++;
    if (we !== 1'b1) $display("FAIL rstmid_in_wr got we=%b exp 1", we); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, we, mem_ready} !== 4'b0001 || a_0 !== 32'd0 || wd_0 !== 32'd0 || ones_cnt !== 8'd0)
      $display("FAIL rstmid_outputs got ctrl=%b a0=%h wd0=%h ones=%0d exp 0001/0/0/0",
               {busy, done, we, mem_ready}, a_0, wd_0, ones_cnt);
    else pass_cnt++;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    total_cnt++;
    if (done_cnt !== 0) $display("FAIL rstmid_no_done got %0d active cycles exp 0", done_cnt); else pass_cnt++;
    total_cnt++;
    if (mem[110] !== 16'h5A5A) $display("FAIL rstmid_no_write got %h exp 5a5a", mem[110]); else pass_cnt++;
    for (int k = 0; k < 8; k++) mem[32+k] = 16'h0;
    issue_start(7'd16, 7'd32, 7'd8, 1'b0);
    run_to_done(20);
    bad = 0;
    for (int k = 0; k < 8; k++) if (mem[32+k] !== 16'(k + 1)) bad++;
    total_cnt++;
    if (done_at !== 3 || ones_cnt !== 8'd4 || bad != 0)
      $display("FAIL rstmid_restart got done_at=%0d ones=%0d bad=%0d exp 3/4/0", done_at, ones_cnt, bad);
    else pass_cnt++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 16'h5A5A;
    test_reset();
    test_copy8();
    test_partial_invert();
    test_len0();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
